// File: rtl/pwm_ramp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ramp_ctrl_pkg
// Description : Shared constants, ramp FSM state encoding and the target
//               clamp helper for the PWM ramp controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_ramp_ctrl_pkg;

    // One PWM period is PERIOD clock cycles; duty is expressed in percent.
    localparam int unsigned PERIOD   = 100;
    localparam int unsigned DUTY_MAX = 100;

    // Widths of the period counter and of a duty value (0..100 fits 7 bits).
    localparam int unsigned c_CNT_W  = 7;
    localparam int unsigned c_DUTY_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_UP    = 2'd1,
        ST_DOWN  = 2'd2,
        ST_DWELL = 2'd3
    } ramp_state_t;

    // Requested targets above full scale saturate at 100 %.
    function automatic logic [c_DUTY_W-1:0] clamp_duty(input logic [c_DUTY_W-1:0] pct);
        logic [c_DUTY_W-1:0] res;
        if (pct > c_DUTY_W'(DUTY_MAX)) begin
            res = c_DUTY_W'(DUTY_MAX);
        end else begin
            res = pct;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_core.sv
`default_nettype none
// ============================================================================
// Module      : pwm_core
// Description : PWM period counter and comparator. The counter runs
//               0..PERIOD-1; o_period_end flags the last count of a period
//               and o_pwm is the registered result of (count < duty).
// Ports       : clk          - clock, rising edge
//               rst          - synchronous active-high reset
//               i_duty       - duty in percent, 0..100
//               o_period_end - high while the counter holds its last value
//               o_pwm        - registered PWM waveform
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_core
    import pwm_ramp_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [c_DUTY_W-1:0] i_duty,
    output logic                o_period_end,
    output logic                o_pwm
);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PERIOD - 1);

    logic [c_CNT_W-1:0] r_cnt_q;
    logic [c_CNT_W-1:0] w_cnt_d;
    logic               r_pwm_q;
    logic               w_pwm_d;
    logic               w_last;

    assign w_last = (r_cnt_q == c_CNT_LAST);

    always_comb begin
        w_cnt_d = r_cnt_q + c_CNT_W'(1);
        if (w_last) begin
            w_cnt_d = '0;
        end
        // Duty 100 keeps the output high for every count 0..99, duty 0 never
        // asserts it, so the extremes are flat without special-casing.
        w_pwm_d = (r_cnt_q < i_duty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
            r_pwm_q <= 1'b0;
        end else begin
            r_cnt_q <= w_cnt_d;
            r_pwm_q <= w_pwm_d;
        end
    end

    assign o_period_end = w_last;
    assign o_pwm        = r_pwm_q;

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ramp_ctrl
// Description : PWM generator whose duty ramps toward a requested target in
//               STEP-percent increments, holding each intermediate duty for
//               HOLD PWM periods. Duty changes only at period boundaries.
// Ports       : clk_in     - sole clock, rising edge
//               rst        - synchronous active-high reset
//               req        - one-cycle request to ramp to target
//               target     - requested duty in percent (101..127 clamp to 100)
//               busy       - high while a ramp is in progress
//               done       - one-cycle pulse when the latched target is reached
//               duty_cur   - duty currently applied, 0..100
//               period_end - pulse on the last count of each PWM period
//               pwm_out    - registered PWM waveform
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int unsigned STEP = 10,
    parameter int unsigned HOLD = 4
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                req,
    input  logic [c_DUTY_W-1:0] target,
    output logic                busy,
    output logic                done,
    output logic [c_DUTY_W-1:0] duty_cur,
    output logic                period_end,
    output logic                pwm_out
);

    localparam logic [c_DUTY_W-1:0] c_STEP7     = c_DUTY_W'(STEP);
    localparam logic [7:0]          c_STEP8     = 8'(STEP);
    localparam logic [7:0]          c_HOLD_LAST = 8'(HOLD - 1);

    ramp_state_t         r_state_q;
    ramp_state_t         w_state_d;
    logic [c_DUTY_W-1:0] r_duty_q;
    logic [c_DUTY_W-1:0] w_duty_d;
    logic [c_DUTY_W-1:0] r_tgt_q;
    logic [c_DUTY_W-1:0] w_tgt_d;
    logic [7:0]          r_hold_q;
    logic [7:0]          w_hold_d;
    logic                r_done_q;
    logic                w_done_d;

    logic [c_DUTY_W-1:0] w_req_tgt;
    logic                w_at_tgt;
    logic                w_dir_up;
    logic                w_up_hits;
    logic                w_dn_hits;
    logic                w_period_end;

    pwm_core u_pwm_core (
        .clk          (clk_in),
        .rst          (rst),
        .i_duty       (r_duty_q),
        .o_period_end (w_period_end),
        .o_pwm        (pwm_out)
    );

    assign w_req_tgt = clamp_duty(target);
    assign w_at_tgt  = (r_duty_q == r_tgt_q);
    assign w_dir_up  = (r_tgt_q > r_duty_q);

    // The step limits are evaluated on 8 bits so duty+STEP and tgt+STEP can
    // exceed 100 without wrapping; the chosen result always lies between the
    // current duty and the target, so it fits back into 7 bits.
    assign w_up_hits = ({1'b0, r_duty_q} + c_STEP8) >= {1'b0, r_tgt_q};
    assign w_dn_hits = {1'b0, r_duty_q} <= ({1'b0, r_tgt_q} + c_STEP8);

    always_comb begin
        w_state_d = r_state_q;
        w_duty_d  = r_duty_q;
        w_tgt_d   = r_tgt_q;
        w_hold_d  = r_hold_q;
        w_done_d  = 1'b0;

        if (req) begin
            // A request is accepted in every state. Mid-ramp it replaces the
            // target, restarts the dwell and picks the direction so the next
            // boundary already steps toward the new target.
            w_tgt_d  = w_req_tgt;
            w_hold_d = '0;
            if (w_req_tgt > r_duty_q) begin
                w_state_d = ST_UP;
            end else if (w_req_tgt < r_duty_q) begin
                w_state_d = ST_DOWN;
            end else begin
                w_state_d = ST_IDLE;
                w_done_d  = 1'b1;
            end
            // A ramp that has just landed still reports completion even if a
            // new request arrives in the same cycle.
            if ((r_state_q == ST_DWELL) && w_at_tgt) begin
                w_done_d = 1'b1;
            end
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                end
                ST_UP: begin
                    if (w_period_end) begin
                        w_duty_d  = w_up_hits ? r_tgt_q : (r_duty_q + c_STEP7);
                        w_hold_d  = '0;
                        w_state_d = ST_DWELL;
                    end
                end
                ST_DOWN: begin
                    if (w_period_end) begin
                        w_duty_d  = w_dn_hits ? r_tgt_q : (r_duty_q - c_STEP7);
                        w_hold_d  = '0;
                        w_state_d = ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (w_at_tgt) begin
                        // Final step landed: finish right away, no dwell.
                        w_state_d = ST_IDLE;
                        w_done_d  = 1'b1;
                    end else if (r_hold_q >= c_HOLD_LAST) begin
                        // HOLD-1 boundaries have passed; UP/DOWN then steps on
                        // the HOLD-th one, so each intermediate duty is
                        // applied for exactly HOLD whole periods.
                        w_hold_d  = '0;
                        w_state_d = w_dir_up ? ST_UP : ST_DOWN;
                    end else if (w_period_end) begin
                        w_hold_d = r_hold_q + 8'd1;
                    end
                end
                default: begin
                    w_state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_duty_q  <= '0;
            r_tgt_q   <= '0;
            r_hold_q  <= '0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_duty_q  <= w_duty_d;
            r_tgt_q   <= w_tgt_d;
            r_hold_q  <= w_hold_d;
            r_done_q  <= w_done_d;
        end
    end

    assign busy       = (r_state_q != ST_IDLE);
    assign done       = r_done_q;
    assign duty_cur   = r_duty_q;
    assign period_end = w_period_end;

endmodule
`default_nettype wire
